// File: rtl/counter_pkg.sv
// Shared fetch-address types and default counter parameters.
// Used by the counter, the instruction memory and the PC path.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH     = 32;
    localparam int unsigned COUNTER_STEP      = 4;
    localparam int unsigned COUNTER_RESET_VAL = 0;

    typedef logic [COUNTER_WIDTH-1:0] addr_t;

endpackage

// File: rtl/counter_next.sv
// Next-address logic: q + STEP, wrapping modulo 2^WIDTH, or holding at the
// last reachable value when built with COUNTER_SAT_EN.
module counter_next #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] next_c
);

`ifdef COUNTER_SAT_EN
    logic [WIDTH:0] sum_c;

    // The carry out of the widened sum flags an increment that would overflow.
    always_comb begin
        sum_c  = {1'b0, q_i} + (WIDTH+1)'(STEP);
        next_c = sum_c[WIDTH] ? q_i : sum_c[WIDTH-1:0];
    end
`else
    always_comb begin
        next_c = q_i + WIDTH'(STEP);
    end
`endif

endmodule

// File: rtl/counter.sv
// Free-running fetch-address generator: async reset to RESET_VAL, then +STEP
// per Clk edge. Define COUNTER_SAT_EN to saturate instead of wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = COUNTER_WIDTH,
    parameter int unsigned      STEP      = COUNTER_STEP,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER_RESET_VAL)
) (
    input  logic             Clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    // Reject parameter sets that would break alignment or make the step vanish.
    if (STEP == 0) begin : g_bad_step_zero
        $error("counter: STEP must be nonzero");
    end
    if (WIDTH < 64 && 64'(STEP) >= (64'd1 << WIDTH)) begin : g_bad_step_range
        $error("counter: STEP must be less than 2**WIDTH");
    end
    if (STEP != 0 && (RESET_VAL % WIDTH'(STEP)) != '0) begin : g_bad_reset_val
        $error("counter: RESET_VAL must be a multiple of STEP");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    counter_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q_i    (count_q),
        .next_c (count_d)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default, near-wrap start and 8-bit/step-1 builds
// share one clock and reset; expectations follow COUNTER_SAT_EN when defined.
module tb_counter;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] q_main;
    logic [31:0] q_wrap;
    logic [7:0]  q_small;

    int nchecks = 0;
    int nerrors = 0;

    always #5 Clk = ~Clk;

    counter u_main (
        .Clk   (Clk),
        .reset (reset),
        .q     (q_main)
    );

    counter #(
        .RESET_VAL (32'hFFFF_FFF8)
    ) u_wrap (
        .Clk   (Clk),
        .reset (reset),
        .q     (q_wrap)
    );

    counter #(
        .WIDTH     (8),
        .STEP      (1),
        .RESET_VAL (8'h00)
    ) u_small (
        .Clk   (Clk),
        .reset (reset),
        .q     (q_small)
    );

    typedef struct {
        logic        rst;
        int          edges;
        logic [31:0] exp_main;
        logic [31:0] exp_wrap;
        logic [7:0]  exp_small;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] em, input logic [31:0] ew,
                             input logic [7:0] es);
        check({tag, " main"}, q_main, em);
        check({tag, " wrap"}, q_wrap, ew);
        check({tag, " small"}, {24'd0, q_small}, {24'd0, es});
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp_w;
        logic [7:0]  exp_s;

        // Table: reset level to drive, posedges to advance, expected outputs.
        vecs[0] = '{1'b1, 0,  32'd0,   32'hFFFF_FFF8, 8'd0};
        vecs[1] = '{1'b0, 1,  32'd4,   32'hFFFF_FFFC, 8'd1};
        vecs[2] = '{1'b0, 1,  32'd8,   SAT ? 32'hFFFF_FFFC : 32'h0000_0000, 8'd2};
        vecs[3] = '{1'b0, 1,  32'd12,  SAT ? 32'hFFFF_FFFC : 32'h0000_0004, 8'd3};
        vecs[4] = '{1'b0, 27, 32'd120, SAT ? 32'hFFFF_FFFC : 32'h0000_0070, 8'd30};
        vecs[5] = '{1'b1, 0,  32'd0,   32'hFFFF_FFF8, 8'd0};
        vecs[6] = '{1'b0, 1,  32'd4,   32'hFFFF_FFFC, 8'd1};

        // Reset takes effect without any clock edge.
        reset = 1'b1;
        #1;
        check_all("reset async", 32'd0, 32'hFFFF_FFF8, 8'd0);

        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check_all("reset hold", 32'd0, 32'hFFFF_FFF8, 8'd0);
        end

        @(negedge Clk);
        for (int i = 0; i < 7; i++) begin
            reset = vecs[i].rst;
            #1;
            repeat (vecs[i].edges) @(posedge Clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_main, vecs[i].exp_wrap, vecs[i].exp_small);
            @(negedge Clk);
        end

        // Long run from a fresh reset: step size, alignment, wrap and 8-bit sweep.
        reset = 1'b1;
        #1;
        check_all("rerun reset", 32'd0, 32'hFFFF_FFF8, 8'd0);
        @(negedge Clk);
        reset = 1'b0;
        prev = 32'd0;
        for (int k = 1; k <= 260; k++) begin
            @(posedge Clk);
            #1;
            check("step by 4", q_main - prev, 32'd4);
            check("align main", {30'd0, q_main[1:0]}, 32'd0);
            check("align wrap", {30'd0, q_wrap[1:0]}, 32'd0);
            if (k == 50) check("count 50", q_main, 32'd200);
            if (k == 1)      exp_w = 32'hFFFF_FFFC;
            else if (SAT)    exp_w = 32'hFFFF_FFFC;
            else             exp_w = 32'(4 * (k - 2));
            check("wrap run", q_wrap, exp_w);
            if (SAT && k > 255) exp_s = 8'd255;
            else                exp_s = 8'(k % 256);
            check("small sweep", {24'd0, q_small}, {24'd0, exp_s});
            if (k == 256) check("small wrap", {24'd0, q_small}, SAT ? 32'd255 : 32'd0);
            prev = q_main;
        end
        check("count 260", q_main, 32'd1040);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
